// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Circular buffer of DEPTH fetched 32-bit words that sits
//               between the instruction fetch unit and the decoder. Each
//               entry carries the word, a 3-bit fetch status code, a
//               "lower halfword valid" flag and two halfword prediction
//               bits. The head entry is presented combinationally from
//               storage; a push is visible one cycle later at the earliest.
// Ports       :
//   s_clk_i      in   clock, rising edge
//   s_reset_i    in   synchronous active-high reset (pointers + counter)
//   s_flush_i    in   discard every entry; overrides push, pop and stall
//   s_wval_i     in   fetch response valid
//   s_wdata_i    in   fetched word
//   s_wlp_val_i  in   lower halfword belongs to the program path
//   s_wferr_i    in   fetch status code of the word
//   s_wpred_i    in   predicted-taken per halfword {upper, lower}
//   s_wready_o   out  a write is accepted this cycle
//   s_stall_i    in   consumer holds the head entry
//   s_instr_o    out  head word (0 when empty)
//   s_info_o     out  {ferr, lp_invalid, nop} (5'b00011 when empty)
//   s_pred_o     out  head prediction bits (0 when empty)
//   s_count_o    out  occupied entries, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     s_clk_i,
  input  logic                     s_reset_i,
  input  logic                     s_flush_i,
  input  logic                     s_wval_i,
  input  logic [31:0]              s_wdata_i,
  input  logic                     s_wlp_val_i,
  input  logic [2:0]               s_wferr_i,
  input  logic [1:0]               s_wpred_i,
  output logic                     s_wready_o,
  input  logic                     s_stall_i,
  output logic [31:0]              s_instr_o,
  output logic [4:0]               s_info_o,
  output logic [1:0]               s_pred_o,
  output logic [$clog2(DEPTH):0]   s_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Entry layout: {data[31:0], ferr[2:0], lp_val, pred[1:0]}
  localparam int EW = 38;

  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          empty;
  logic          pop;
  logic          push;
  logic [EW-1:0] wentry;
  logic [EW-1:0] head;

  assign empty = (count_q == '0);

  // A full buffer can still accept a word when the head leaves in the same
  // cycle, so ready depends combinationally on the pop condition.
  assign pop        = ~empty & ~s_stall_i & ~s_flush_i;
  assign s_wready_o = (count_q < DEPTH_C) | pop;
  assign push       = s_wval_i & s_wready_o & ~s_flush_i;

  // A prediction on a discarded lower halfword must never reach the decoder.
  assign wentry = {s_wdata_i, s_wferr_i, s_wlp_val_i,
                   s_wpred_i[1], s_wpred_i[0] & s_wlp_val_i};

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (s_flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap to slot 0.
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; stale contents are masked by the counter.
  always_ff @(posedge s_clk_i) begin
    if (push && !s_reset_i) begin
      mem_q[wptr_q] <= wentry;
    end
  end

  assign head = mem_q[rptr_q];

  always_comb begin
    s_instr_o = 32'h0;
    s_info_o  = 5'b00011;
    s_pred_o  = 2'b00;
    if (!empty) begin
      s_instr_o = head[37:6];
      s_info_o  = {head[5:3], ~head[2], 1'b0};
      s_pred_o  = head[1:0];
    end
  end

  assign s_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Self-checking bench for fetch_buffer. A queue-based model
//               of the buffer is compared against the DUT every cycle, and
//               directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          wval;
  logic [31:0]   wdata;
  logic          wlp;
  logic [2:0]    wferr;
  logic [1:0]    wpred;
  logic          wready;
  logic          stall;
  logic [31:0]   instr;
  logic [4:0]    info;
  logic [1:0]    pred;
  logic [CW-1:0] count;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .s_clk_i     (clk),
    .s_reset_i   (rst),
    .s_flush_i   (flush),
    .s_wval_i    (wval),
    .s_wdata_i   (wdata),
    .s_wlp_val_i (wlp),
    .s_wferr_i   (wferr),
    .s_wpred_i   (wpred),
    .s_wready_o  (wready),
    .s_stall_i   (stall),
    .s_instr_o   (instr),
    .s_info_o    (info),
    .s_pred_o    (pred),
    .s_count_o   (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  ferr;
    logic        lp;
    logic [1:0]  pred;
  } entry_t;

  entry_t q[$];
  bit     model_ok = 0;

  always @(negedge clk) begin
    bit     m_pop, m_rdy;
    entry_t e;
    m_pop = (q.size() != 0) && !stall && !flush;
    m_rdy = (q.size() < DEPTH) || m_pop;
    if (model_ok) begin
      chk("m_count", 40'(count), 40'(q.size()));
      chk("m_wready", 40'(wready), 40'(m_rdy));
      if (q.size() == 0) begin
        chk("m_instr", 40'(instr), 40'h0);
        chk("m_info", 40'(info), 40'h03);
        chk("m_pred", 40'(pred), 40'h0);
      end else begin
        chk("m_instr", 40'(instr), 40'(q[0].data));
        chk("m_info", 40'(info), 40'({q[0].ferr, ~q[0].lp, 1'b0}));
        chk("m_pred", 40'(pred), 40'(q[0].pred));
      end
    end
    if (rst) begin
      q.delete();
      model_ok = 1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (m_pop) void'(q.pop_front());
      if (wval && m_rdy) begin
        e.data = wdata;
        e.ferr = wferr;
        e.lp   = wlp;
        e.pred = {wpred[1], wpred[0] & wlp};
        q.push_back(e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic st);
    wval = 0; wdata = 32'h0; wlp = 1; wferr = 3'd0; wpred = 2'b00;
    stall = st; flush = 0; rst = 0;
  endtask

  task automatic put(input logic [31:0] d, input logic lp, input logic [2:0] fe,
                     input logic [1:0] pr, input logic st);
    wval = 1; wdata = d; wlp = lp; wferr = fe; wpred = pr;
    stall = st; flush = 0; rst = 0;
  endtask

  task automatic chk_empty(input string name);
    chk({name, "_count"}, 40'(count), 40'h0);
    chk({name, "_info"}, 40'(info), 40'h03);
    chk({name, "_instr"}, 40'(instr), 40'h0);
    chk({name, "_pred"}, 40'(pred), 40'h0);
  endtask

  initial begin
    idle(1'b0);
    rst = 1;
    step; step;
    idle(1'b0);
    // reset state
    chk_empty("rst");
    chk("rst_wready", 40'(wready), 40'h1);
    step;

    // single word in and out
    put(32'h0000_0013, 1, 3'd0, 2'b00, 0);
    step;
    idle(1'b0);
    chk("one_instr", 40'(instr), 40'h13);
    chk("one_info", 40'(info), 40'h00);
    chk("one_count", 40'(count), 40'h1);
    step;
    chk_empty("one_drain");

    // fill under stall (pointer wraps: write pointer starts at slot 1)
    for (int i = 0; i < DEPTH; i++) begin
      put(32'hA000_0000 + i, 1, 3'(i), 2'(i), 1);
      step;
    end
    idle(1'b1);
    #1;
    chk("full_count", 40'(count), 40'(DEPTH));
    chk("full_wready", 40'(wready), 40'h0);
    put(32'hDEAD_BEEF, 1, 3'd7, 2'b11, 1);
    step;
    idle(1'b1);
    chk("ignored_count", 40'(count), 40'(DEPTH));
    chk("ignored_head", 40'(instr), 40'hA000_0000);
    chk("hold_info", 40'(info), 40'h00);
    step;
    chk("hold_stable", 40'(instr), 40'hA000_0000);
    idle(1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      step;
      chk("drain_order", 40'(instr), 40'(32'hA000_0000 + i));
      chk("drain_info", 40'(info), 40'({3'(i), 2'b00}));
    end
    step;
    chk_empty("drain_end");

    // full buffer with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) begin
      put(32'hB000_0000 + i, 1, 3'd0, 2'b10, 1);
      step;
    end
    put(32'hB000_0004, 1, 3'd5, 2'b01, 0);
    #1;
    chk("pp_wready", 40'(wready), 40'h1);
    step;
    idle(1'b0);
    chk("pp_count", 40'(count), 40'(DEPTH));
    chk("pp_head", 40'(instr), 40'hB000_0001);
    for (int i = 2; i <= DEPTH; i++) begin
      step;
      chk("pp_order", 40'(instr), 40'(32'hB000_0000 + i));
    end
    chk("pp_last_info", 40'(info), 40'h14);
    chk("pp_last_pred", 40'(pred), 40'h1);
    step;
    chk_empty("pp_end");

    // unaligned target: lower-halfword prediction dropped
    put(32'hC000_0001, 0, 3'd0, 2'b01, 1);
    step;
    put(32'hC000_0002, 0, 3'd2, 2'b11, 1);
    step;
    idle(1'b1);
    chk("lp_info", 40'(info), 40'h02);
    chk("lp_pred", 40'(pred), 40'h0);
    idle(1'b0);
    step;
    chk("lp2_info", 40'(info), 40'h0A);
    chk("lp2_pred", 40'(pred), 40'h2);
    step;
    chk_empty("lp_end");

    // flush with a concurrent write
    for (int i = 0; i < 3; i++) begin
      put(32'hD000_0000 + i, 1, 3'd0, 2'b00, 1);
      step;
    end
    put(32'hD000_00FF, 1, 3'd1, 2'b00, 0);
    flush = 1;
    step;
    idle(1'b0);
    chk_empty("flush");
    step;
    chk_empty("flush_after");

    // reset mid-operation
    for (int i = 0; i < 2; i++) begin
      put(32'hE000_0000 + i, 1, 3'd3, 2'b00, 1);
      step;
    end
    idle(1'b1);
    rst = 1;
    step;
    idle(1'b1);
    chk_empty("mrst");
    chk("mrst_wready", 40'(wready), 40'h1);
    put(32'hF000_0000, 1, 3'd0, 2'b00, 1);
    step;
    put(32'hF000_0001, 1, 3'd0, 2'b00, 0);
    step;
    idle(1'b0);
    chk("mrst_first", 40'(instr), 40'hF000_0001);
    chk("mrst_count", 40'(count), 40'h1);
    step;

    // mixed traffic, checked by the model only
    for (int i = 0; i < 40; i++) begin
      wval  = (i % 3) != 2;
      wdata = 32'h1234_0000 + i;
      wlp   = (i % 5) != 0;
      wferr = 3'(i);
      wpred = 2'(i >> 1);
      stall = (i % 4) == 1 || (i % 7) == 3;
      flush = (i == 25);
      rst   = 0;
      step;
    end
    idle(1'b0);
    step; step; step; step; step;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
